// File: rtl/universal_barrel_shifter_if.sv
// Operand/result bundle for universal_barrel_shifter.
// The master side drives operands and the slave side returns the registered result.
interface universal_barrel_shifter_if #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
);
    logic               in_valid;
    logic [WIDTH-1:0]   a;
    logic [SHAMT_W-1:0] shift;
    logic               shift_choice;
    logic               rotate;
    logic [WIDTH-1:0]   out;
    logic               out_valid;

    modport master (
        output in_valid, a, shift, shift_choice, rotate,
        input  out, out_valid
    );

    modport slave (
        input  in_valid, a, shift, shift_choice, rotate,
        output out, out_valid
    );
endinterface

// File: rtl/universal_barrel_shifter.sv
// Registered logical barrel shifter: a log2 network of 1/2/4/8... stages, then one output register.
// Optional macro ROTATE_EN adds rotate support; without it the rotate input is ignored.
module universal_barrel_shifter #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    universal_barrel_shifter_if.slave    bus
);
    logic [WIDTH-1:0] w_stage [0:SHAMT_W];
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;

    // Right shifts reuse the left-shift network by mirroring the word on the way in and out.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mirror
            assign w_stage[0][gi] = bus.shift_choice ? bus.a[gi] : bus.a[WIDTH-1-gi];
            assign w_result[gi]   = bus.shift_choice ? w_stage[SHAMT_W][gi]
                                                     : w_stage[SHAMT_W][WIDTH-1-gi];
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
            localparam int STEP = 1 << gi;
`ifdef ROTATE_EN
            assign w_stage[gi+1] = !bus.shift[gi] ? w_stage[gi] :
                                   bus.rotate     ? {w_stage[gi][WIDTH-1-STEP:0],
                                                     w_stage[gi][WIDTH-1:WIDTH-STEP]} :
                                                    {w_stage[gi][WIDTH-1-STEP:0],
                                                     {STEP{1'b0}}};
`else
            assign w_stage[gi+1] = !bus.shift[gi] ? w_stage[gi] :
                                                    {w_stage[gi][WIDTH-1-STEP:0],
                                                     {STEP{1'b0}}};
`endif
        end
    endgenerate

`ifndef ROTATE_EN
    logic w_unused_rotate;
    assign w_unused_rotate = bus.rotate;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_out <= w_result;
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_universal_barrel_shifter.sv
// Self-checking bench for universal_barrel_shifter: directed cases plus random traffic
// against an arithmetic shift/rotate reference model (honours ROTATE_EN when defined).
module tb_universal_barrel_shifter;
    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_compared = 0;
    int   n_mismatched = 0;
    logic [WIDTH-1:0] exp_out = '0;

    universal_barrel_shifter_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

    universal_barrel_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, input int sh,
                                               input logic left, input logic rot);
        int unsigned v;
        int unsigned r;
        v = a;
        if (left) r = (v << sh) & 32'hFFFF;
        else      r = v >> sh;
`ifdef ROTATE_EN
        if (rot && sh != 0) begin
            if (left) r = r | (v >> (WIDTH - sh));
            else      r = r | ((v << (WIDTH - sh)) & 32'hFFFF);
        end
`endif
        return r[WIDTH-1:0];
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
        n_compared++;
        assert (obs === expv) else begin
            n_mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock of traffic: drive at negedge, sample 1 time unit after the next posedge.
    task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] a,
                        input int sh, input logic left, input logic rot);
        @(negedge clk);
        bus.in_valid     = v;
        bus.a            = a;
        bus.shift        = sh[SHAMT_W-1:0];
        bus.shift_choice = left;
        bus.rotate       = rot;
        @(posedge clk);
        #1;
        if (v) exp_out = model(a, sh, left, rot);
        $display("%s: v=%0b a=%h sh=%0d left=%0b rot=%0b -> out=%h out_valid=%0b",
                 tag, v, a, sh, left, rot, bus.out, bus.out_valid);
        check({tag, ".out"}, bus.out, exp_out);
        check({tag, ".out_valid"}, {{(WIDTH-1){1'b0}}, bus.out_valid}, {{(WIDTH-1){1'b0}}, v});
    endtask

    initial begin
        logic [WIDTH-1:0] rot_left_exp;
        logic [WIDTH-1:0] rot_right_exp;
        bus.in_valid = 1'b1;
        bus.a = 16'hFFFF;
        bus.shift = 4'd5;
        bus.shift_choice = 1'b1;
        bus.rotate = 1'b0;

        // Reset held with in_valid asserted must still clear the outputs.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.out", bus.out, 16'h0000);
        check("reset.out_valid", {15'd0, bus.out_valid}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        exp_out = '0;

        step("left_b252", 1'b1, 16'hB252, 3, 1'b1, 1'b0);
        check("left_b252.const", bus.out, 16'h9290);
        step("right_b252", 1'b1, 16'hB252, 3, 1'b0, 1'b0);
        check("right_b252.const", bus.out, 16'h164A);
        step("ffff_l0", 1'b1, 16'hFFFF, 0, 1'b1, 1'b0);
        check("ffff_l0.const", bus.out, 16'hFFFF);
        step("ffff_r0", 1'b1, 16'hFFFF, 0, 1'b0, 1'b0);
        check("ffff_r0.const", bus.out, 16'hFFFF);
        step("8001_l15", 1'b1, 16'h8001, 15, 1'b1, 1'b0);
        check("8001_l15.const", bus.out, 16'h8000);
        step("8001_r15", 1'b1, 16'h8001, 15, 1'b0, 1'b0);
        check("8001_r15.const", bus.out, 16'h0001);

`ifdef ROTATE_EN
        rot_left_exp  = 16'h9295;
        rot_right_exp = 16'h564A;
`else
        rot_left_exp  = 16'h9290;
        rot_right_exp = 16'h164A;
`endif
        step("rot_left", 1'b1, 16'hB252, 3, 1'b1, 1'b1);
        check("rot_left.const", bus.out, rot_left_exp);
        step("rot_right", 1'b1, 16'hB252, 3, 1'b0, 1'b1);
        check("rot_right.const", bus.out, rot_right_exp);

        for (int s = 0; s < WIDTH; s++) begin
            step($sformatf("stream%0d", s), 1'b1, 16'h0001, s, 1'b1, 1'b0);
            check($sformatf("stream%0d.const", s), bus.out, 16'h0001 << s);
        end
        step("hold", 1'b0, 16'h1234, 2, 1'b0, 1'b0);
        check("hold.const", bus.out, 16'h8000);

        for (int i = 0; i < 300; i++) begin
            step($sformatf("rand%0d", i), ($urandom_range(0, 9) < 8),
                 WIDTH'($urandom), int'($urandom_range(0, WIDTH-1)),
                 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
